alu_seq: RTL and testbench

- Parametrised-width ALU that accepts operations through a valid/ready handshake and returns a registered result plus status flags.
- Supports single-cycle logic/arithmetic ops, iterative shifts (1 bit/cycle) and an iterative shift-add multiply.
- Sits between operand registers and the display/writeback path.
- Takes the place of the fixed 4-bit combinational ALU in the next-generation datapath.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/alu_comb.sv | 33 +++
 rtl/alu_seq.sv | 149 ++++++++++++++
 tb/tb_alu_seq.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM states and flag helper shared by the sequential ALU.
package alu_pkg;
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_NOT = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_SLT = 4'd6;
  localparam logic [3:0] OP_EQ  = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SRL = 4'd9;
  localparam logic [3:0] OP_SRA = 4'd10;
  localparam logic [3:0] OP_MUL = 4'd11;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

  function automatic flags_t alu_flags(input logic [3:0] op, input logic a_msb, input logic b_msb,
                                       input logic sum_msb, input logic carry, input logic res_zero,
                                       input logic res_msb);
    flags_t f;
    logic arith;
    logic bp_msb;
    arith = (op == OP_ADD) || (op == OP_SUB);
    bp_msb = (op == OP_SUB) ? ~b_msb : b_msb;
    f.z = res_zero;
    f.n = res_msb;
    f.c = arith & carry;
    f.v = arith & (a_msb == bp_msb) & (sum_msb != a_msb);
    return f;
  endfunction
endpackage

// File: rtl/alu_comb.sv
// alu_comb: single-cycle datapath for opcodes ADD..EQ; carry/overflow are zero for non-arithmetic ops.
module alu_comb
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [3:0]   op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] res_o,
  output logic         carry_o,
  output logic         ovf_o
);
  logic [W-1:0] bx;
  logic [W-1:0] sum;
  logic         cout;
  flags_t       f;

  always_comb begin
    bx = (op_i == OP_SUB) ? ~b_i : b_i;
    {cout, sum} = {1'b0, a_i} + {1'b0, bx} + (W+1)'(op_i == OP_SUB);
    res_o = (op_i == OP_ADD || op_i == OP_SUB) ? sum :
            (op_i == OP_NOT) ? ~a_i :
            (op_i == OP_AND) ? (a_i & b_i) :
            (op_i == OP_OR)  ? (a_i | b_i) :
            (op_i == OP_XOR) ? (a_i ^ b_i) :
            (op_i == OP_SLT) ? W'($signed(a_i) < $signed(b_i)) :
            (op_i == OP_EQ)  ? W'(a_i == b_i) : '0;
    f = alu_flags(op_i, a_i[W-1], b_i[W-1], sum[W-1], cout, 1'b0, 1'b0);
    carry_o = f.c;
    ovf_o = f.v;
  end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: handshaked ALU; single-cycle ops via alu_comb, iterative 1-bit/cycle shifts and shift-add multiply.
module alu_seq
  import alu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         flag_z,
  output logic         flag_n,
  output logic         flag_c,
  output logic         flag_v,
  output logic         err
);
  localparam int SW = $clog2(W);
  localparam int CW = SW + 1;

  state_t       state_q, state_d;
  logic [3:0]   op_q, op_d;
  logic [W-1:0] sh_q, sh_d;
  logic [W-1:0] mb_q, mb_d;
  logic [W-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0] res_q, res_d;
  flags_t       flags_q, flags_d;
  logic         err_q, err_d;

  logic [W-1:0] comb_res;
  logic         comb_c, comb_v;
  logic [W-1:0] nxt_sh, nxt_acc, res_n;
  logic         load, c_n, v_n;

  alu_comb #(.W(W)) u_comb (
    .op_i   (op),
    .a_i    (a),
    .b_i    (b),
    .res_o  (comb_res),
    .carry_o(comb_c),
    .ovf_o  (comb_v)
  );

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign flag_z    = flags_q.z;
  assign flag_n    = flags_q.n;
  assign flag_c    = flags_q.c;
  assign flag_v    = flags_q.v;
  assign err       = err_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sh_d    = sh_q;
    mb_d    = mb_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    flags_d = flags_q;
    err_d   = err_q;
    load    = 1'b0;
    res_n   = '0;
    c_n     = 1'b0;
    v_n     = 1'b0;
    nxt_sh  = (op_q == OP_SLL) ? (sh_q << 1) :
              (op_q == OP_SRL) ? (sh_q >> 1) : {sh_q[W-1], sh_q[W-1:1]};
    nxt_acc = acc_q + (mb_q[0] ? sh_q : '0);
    case (state_q)
      IDLE: if (in_valid) begin
        op_d  = op;
        sh_d  = a;
        mb_d  = b;
        acc_d = '0;
        err_d = op > OP_MUL;
        if (op <= OP_EQ) begin
          load = 1'b1;
          res_n = comb_res;
          c_n = comb_c;
          v_n = comb_v;
        end else if (op == OP_MUL) begin
          cnt_d = CW'(W);
          state_d = BUSY;
        end else if (op > OP_MUL) begin
          load = 1'b1;
        end else if (b[SW-1:0] == '0) begin
          load = 1'b1;
          res_n = a;
        end else begin
          cnt_d = {1'b0, b[SW-1:0]};
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - 1'b1;
        if (op_q == OP_MUL) begin
          acc_d = nxt_acc;
          sh_d = sh_q << 1;
          mb_d = mb_q >> 1;
        end else begin
          sh_d = nxt_sh;
        end
        if (cnt_q == CW'(1)) begin
          load = 1'b1;
          res_n = (op_q == OP_MUL) ? nxt_acc : nxt_sh;
        end
      end
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // every path into DONE goes through load, so result and flags update together
    if (load) begin
      state_d = DONE;
      res_d = res_n;
      flags_d = '{z: res_n == '0, n: res_n[W-1], c: c_n, v: v_n};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      sh_q    <= '0;
      mb_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      sh_q    <= sh_d;
      mb_q    <= mb_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random ops against an arithmetic reference model, including latency and back-pressure.
module tb_alu_seq;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] op = '0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] result;
  logic       flag_z, flag_n, flag_c, flag_v, err;
  int checks = 0;
  int errors = 0;

  alu_seq #(.W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .flag_z(flag_z), .flag_n(flag_n), .flag_c(flag_c), .flag_v(flag_v), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                                output logic [7:0] r, output logic [3:0] fl, output logic e,
                                output int lat);
    int ux = int'(x);
    int uy = int'(y);
    int sx = int'($signed(x));
    int sy = int'($signed(y));
    int t;
    logic c = 1'b0;
    logic v = 1'b0;
    e = 1'b0;
    lat = 1;
    r = '0;
    case (o)
      4'd0: begin t = ux + uy; r = t[7:0]; c = t > 255; v = (sx + sy > 127) || (sx + sy < -128); end
      4'd1: begin t = ux - uy; r = t[7:0]; c = ux >= uy; v = (sx - sy > 127) || (sx - sy < -128); end
      4'd2: r = ~x;
      4'd3: r = x & y;
      4'd4: r = x | y;
      4'd5: r = x ^ y;
      4'd6: r = (sx < sy) ? 8'd1 : 8'd0;
      4'd7: r = (x == y) ? 8'd1 : 8'd0;
      4'd8: begin r = x << y[2:0]; lat = 1 + int'(y[2:0]); end
      4'd9: begin r = x >> y[2:0]; lat = 1 + int'(y[2:0]); end
      4'd10: begin r = $signed(x) >>> y[2:0]; lat = 1 + int'(y[2:0]); end
      4'd11: begin t = ux * uy; r = t[7:0]; lat = 9; end
      default: e = 1'b1;
    endcase
    fl = {r == 8'd0, r[7], c, v};
  endfunction

  task automatic do_op(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y, input int hold);
    logic [7:0] r;
    logic [3:0] fl;
    logic e;
    int lat, n;
    model(o, x, y, r, fl, e, lat);
    @(negedge clk);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'(lat));
    chk("result", 32'(result), 32'(r));
    chk("flags_zncv", 32'({flag_z, flag_n, flag_c, flag_v}), 32'(fl));
    chk("err", 32'(err), 32'(e));
    chk("in_ready_done", 32'(in_ready), 32'd0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1; op = 4'($urandom); a = 8'($urandom); b = 8'($urandom);
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_ready", 32'(in_ready), 32'd0);
      chk("hold_result", 32'(result), 32'(r));
      chk("hold_flags", 32'({flag_z, flag_n, flag_c, flag_v, err}), 32'({fl, e}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("drain_valid", 32'(out_valid), 32'd0);
    chk("drain_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_flags", 32'({flag_z, flag_n, flag_c, flag_v, err}), 32'd0);
    do_op(4'd0, 8'h7F, 8'h01, 0);
    chk("add_7f_01", 32'({result, flag_z, flag_n, flag_c, flag_v}), 32'({8'h80, 4'b0101}));
    do_op(4'd1, 8'h05, 8'h05, 0);
    chk("sub_eq_5", 32'({result, flag_z, flag_n, flag_c, flag_v}), 32'({8'h00, 4'b1010}));
    do_op(4'd7, 8'h05, 8'h05, 0);
    chk("eq_5", 32'(result), 32'h01);
    do_op(4'd10, 8'h90, 8'd3, 0);
    chk("sra_90_3", 32'(result), 32'hF2);
    do_op(4'd8, 8'hA5, 8'd0, 0);
    do_op(4'd11, 8'h0D, 8'h0B, 0);
    chk("mul_0d_0b", 32'(result), 32'h8F);
    do_op(4'd11, 8'h20, 8'h10, 0);
    chk("mul_zero_z", 32'({result, flag_z}), 32'({8'h00, 1'b1}));
    do_op(4'd3, 8'hF0, 8'h3C, 5);
    do_op(4'd11, 8'hFF, 8'hFF, 5);
    do_op(4'd14, 8'h12, 8'h34, 0);
    chk("illegal_14", 32'({result, flag_z, err}), 32'({8'h00, 1'b1, 1'b1}));
    @(negedge clk);
    in_valid = 1'b1; op = 4'd11; a = 8'h0D; b = 8'h0B;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", 32'(in_ready), 32'd1);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", 32'(result), 32'd0);
    chk("midrst_flags", 32'({flag_z, flag_n, flag_c, flag_v, err}), 32'd0);
    repeat (12) @(negedge clk);
    chk("midrst_noresult", 32'(out_valid), 32'd0);
    do_op(4'd1, 8'h80, 8'h01, 0);
    for (int i = 0; i < 200; i++)
      do_op(4'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
